// File: rtl/m68030_bus_master.sv
// m68030_bus_master
// Bus initiator for a 68030-style asynchronous bus. It accepts one transfer
// (byte, word, 3-byte or long) at a time on a valid/ready port and runs as
// many bus cycles as needed. The number of cycles depends on the alignment
// and on the port width that the slave reports on DSACKn.
//
// Ports
//   clk, RESETn        : system clock, synchronous active-low reset
//   req_*              : request port (valid/ready, rw, byte address, size, wdata)
//   rsp_*              : one-cycle completion pulse with read data and error flag
//   ADR_OUT, SIZE, RWn : address phase of the current bus cycle
//   DATA_OUT, DATA_IN  : data lanes, lane0 = [31:24]
//   ASn, DSn, DBENn    : bus strobes (active low)
//   DSACKn             : slave acknowledge / port width (11 = wait)
module m68030_bus_master #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        RESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] ADR_OUT,
  output logic [31:0] DATA_OUT,
  input  logic [31:0] DATA_IN,
  output logic [1:0]  SIZE,
  output logic        RWn,
  output logic        ASn,
  output logic        DSn,
  output logic        DBENn,
  input  logic [1:0]  DSACKn
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_END,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [31:0]     a_reg, a_next;        // address of the next bus cycle
  logic [2:0]      r_reg, r_next;        // bytes still to move (1..4)
  logic [31:0]     op_reg, op_next;      // remaining write bytes, left-justified
  logic [31:0]     acc_reg, acc_next;    // read bytes collected so far
  logic            rw_reg, rw_next;
  logic            abort_reg, abort_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  // Byte i of a left-justified operand.
  function automatic logic [7:0] op_byte(input logic [31:0] v, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = v[31:24];
      2'd1:    b = v[23:16];
      2'd2:    b = v[15:8];
      default: b = v[7:0];
    endcase
    return b;
  endfunction

  // Port width from the acknowledge, and the offset of the address within it.
  logic [2:0]  port_bytes;
  logic [1:0]  port_off;
  logic [2:0]  room;
  logic [2:0]  n_move;
  logic [31:0] lane_shift;
  logic [31:0] rd_bytes;

  always_comb begin
    case (DSACKn)
      2'b00: begin
        port_bytes = 3'd4;
        port_off   = a_reg[1:0];
      end
      2'b01: begin
        port_bytes = 3'd2;
        port_off   = {1'b0, a_reg[0]};
      end
      default: begin
        port_bytes = 3'd1;
        port_off   = 2'd0;
      end
    endcase
    room   = port_bytes - {1'b0, port_off};
    n_move = (r_reg < room) ? r_reg : room;
    // Bring the first transferred lane to the top, then keep only n_move bytes
    // right-justified so they can be appended to the accumulator.
    lane_shift = DATA_IN << {port_off, 3'b000};
    rd_bytes   = lane_shift >> {(3'd4 - n_move), 3'b000};
  end

  // Write lane steering. Lanes at or above the address offset carry the
  // operand in order; lanes below it replicate the leading bytes so that an
  // 8- or 16-bit port finds its byte on the lanes it actually wires up.
  logic [1:0]  off;
  logic [31:0] wr_data;
  assign off = a_reg[1:0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
      localparam logic [1:0] LANE = 2'(gi);
      logic [1:0] idx;
      logic [7:0] lane_byte;
      always_comb begin
        idx       = LANE - off;
        lane_byte = 8'h00;
        if (LANE >= off) begin
          if ({1'b0, idx} < r_reg) lane_byte = op_byte(op_reg, idx);
        end else if (LANE == 2'd1 && off == 2'd2) begin
          lane_byte = op_reg[23:16];
        end else begin
          lane_byte = op_reg[31:24];
        end
      end
      assign wr_data[31-8*gi -: 8] = lane_byte;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      state_reg <= S_IDLE;
      a_reg     <= '0;
      r_reg     <= '0;
      op_reg    <= '0;
      acc_reg   <= '0;
      rw_reg    <= 1'b1;
      abort_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      r_reg     <= r_next;
      op_reg    <= op_next;
      acc_reg   <= acc_next;
      rw_reg    <= rw_next;
      abort_reg <= abort_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    r_next     = r_reg;
    op_next    = op_reg;
    acc_next   = acc_reg;
    rw_next    = rw_reg;
    abort_next = abort_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          a_next     = req_addr;
          rw_next    = req_rw;
          acc_next   = '0;
          abort_next = 1'b0;
          case (req_size)
            2'b00: begin r_next = 3'd4; op_next = req_wdata; end
            2'b01: begin r_next = 3'd1; op_next = {req_wdata[7:0], 24'h0}; end
            2'b10: begin r_next = 3'd2; op_next = {req_wdata[15:0], 16'h0}; end
            default: begin r_next = 3'd3; op_next = {req_wdata[23:0], 8'h0}; end
          endcase
          state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_next   = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // An acknowledge arriving on the last allowed clock still wins.
        if (DSACKn != 2'b11) begin
          if (rw_reg) acc_next = (acc_reg << {n_move, 3'b000}) | rd_bytes;
          else        op_next  = op_reg << {n_move, 3'b000};
          a_next     = a_reg + {29'd0, n_move};
          r_next     = r_reg - n_move;
          state_next = S_END;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          abort_next = 1'b1;
          state_next = S_END;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_END: begin
        // Do not start another cycle while the previous acknowledge is held.
        if (DSACKn == 2'b11) begin
          if (r_reg != 3'd0 && !abort_reg) state_next = S_ADDR;
          else                             state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  logic in_cycle;
  assign in_cycle  = (state_reg == S_ADDR) || (state_reg == S_WAIT);

  assign req_ready = (state_reg == S_IDLE);
  assign rsp_valid = (state_reg == S_DONE);
  assign rsp_err   = (state_reg == S_DONE) && abort_reg;
  assign rsp_rdata = ((state_reg == S_DONE) && rw_reg) ? acc_reg : 32'h0;

  assign ASn      = !in_cycle;
  assign DSn      = (state_reg != S_WAIT);
  assign DBENn    = (state_reg != S_WAIT);
  assign ADR_OUT  = in_cycle ? a_reg : 32'h0;
  assign SIZE     = in_cycle ? r_reg[1:0] : 2'b00;
  assign RWn      = in_cycle ? rw_reg : 1'b1;
  assign DATA_OUT = (in_cycle && !rw_reg) ? wr_data : 32'h0;

endmodule

// File: tb/tb_m68030_bus_master.sv
module tb_m68030_bus_master;

  logic        clk = 1'b0;
  logic        RESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b1;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ADR_OUT;
  logic [31:0] DATA_OUT;
  logic [31:0] DATA_IN = '0;
  logic [1:0]  SIZE;
  logic        RWn;
  logic        ASn;
  logic        DSn;
  logic        DBENn;
  logic [1:0]  DSACKn = 2'b11;

  always #5 clk = ~clk;

  m68030_bus_master #(.TIMEOUT(64)) dut (
    .clk(clk), .RESETn(RESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ADR_OUT(ADR_OUT), .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN),
    .SIZE(SIZE), .RWn(RWn), .ASn(ASn), .DSn(DSn), .DBENn(DBENn),
    .DSACKn(DSACKn)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave memory (written by the bus) and reference memory (written by the model).
  logic [7:0] slv_mem [1024];
  logic [7:0] ref_mem [1024];

  logic [1:0] port_code = 2'b00;
  bit         no_resp   = 1'b0;
  int         ack_delay = 0;
  int         ack_hold  = 0;
  int         dly_cnt   = 0;
  int         hold_cnt  = 0;
  int         wait_clks = 0;
  bit         acked     = 1'b0;

  logic [31:0] cyc_adr  [$];
  logic [1:0]  cyc_size [$];
  logic [31:0] cyc_data [$];
  logic        cyc_rw   [$];

  // Behavioural slave: a port of 1, 2 or 4 bytes moves bytes from the cycle
  // address up to the end of its own width, on the lanes it wires up.
  task automatic slave_xfer();
    int p, rem, base, nb, lane;
    logic [31:0] a;
    a    = ADR_OUT;
    rem  = (SIZE == 2'b00) ? 4 : int'(SIZE);
    p    = (port_code == 2'b00) ? 4 : (port_code == 2'b01) ? 2 : 1;
    base = int'(a % p);
    nb   = (rem < p - base) ? rem : p - base;
    if (p == 1) base = 0;
    DATA_IN = $urandom();
    for (int k = 0; k < nb; k++) begin
      lane = base + k;
      if (RWn) DATA_IN[31-8*lane -: 8] = slv_mem[(a + k) % 1024];
      else     slv_mem[(a + k) % 1024] = DATA_OUT[31-8*lane -: 8];
    end
  endtask

  always @(negedge clk) begin
    if (ASn == 1'b0 && DSn == 1'b1) begin
      cyc_adr.push_back(ADR_OUT);
      cyc_size.push_back(SIZE);
      cyc_data.push_back(DATA_OUT);
      cyc_rw.push_back(RWn);
    end
    if (DSn == 1'b0) begin
      wait_clks++;
      if (!acked && !no_resp) begin
        if (dly_cnt >= ack_delay) begin
          slave_xfer();
          DSACKn   = port_code;
          acked    = 1'b1;
          hold_cnt = 0;
        end else begin
          dly_cnt++;
        end
      end
    end else begin
      if (acked && hold_cnt < ack_hold) begin
        hold_cnt++;
      end else begin
        DSACKn  = 2'b11;
        DATA_IN = '0;
        acked   = 1'b0;
        dly_cnt = 0;
      end
    end
  end

  // Runs one transfer and, when the slave responds, checks data, memory and
  // the sequence of bus cycles against a byte-level model.
  task automatic xfer(input logic rw, input logic [31:0] addr, input logic [1:0] sz,
                      input logic [31:0] wd, input logic [1:0] pc,
                      output logic [31:0] rd, output logic er);
    int cnt, p, guard, a, r, nb, idx;
    logic [31:0] exp_rd;
    cnt       = (sz == 2'b00) ? 4 : int'(sz);
    port_code = pc;
    ack_delay = $urandom_range(0, 2);
    ack_hold  = $urandom_range(0, 1);
    cyc_adr.delete(); cyc_size.delete(); cyc_data.delete(); cyc_rw.delete();
    @(negedge clk);
    guard = 0;
    while (req_ready !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    check("req_ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_size = sz; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom(); req_wdata = $urandom(); req_size = 2'($urandom());
    guard = 0;
    while (rsp_valid !== 1'b1 && guard < 2000) begin @(negedge clk); guard++; end
    check("rsp_arrived", {31'd0, rsp_valid}, 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
    if (!no_resp) begin
      exp_rd = 32'h0;
      for (int k = 0; k < cnt; k++) begin
        if (rw) exp_rd = (exp_rd << 8) | {24'd0, ref_mem[(addr + k) % 1024]};
        else    ref_mem[(addr + k) % 1024] = 8'(wd >> (8 * (cnt - 1 - k)));
      end
      check("rsp_rdata", rd, exp_rd);
      check("rsp_err", {31'd0, er}, 32'd0);
      for (int k = -1; k <= 4; k++) begin
        idx = int'((addr + k) % 1024);
        check("mem_byte", {24'd0, slv_mem[idx]}, {24'd0, ref_mem[idx]});
      end
      p = (pc == 2'b00) ? 4 : (pc == 2'b01) ? 2 : 1;
      a = int'(addr); r = cnt; idx = 0;
      while (r > 0) begin
        nb = p - (a % p);
        if (nb > r) nb = r;
        if (idx < cyc_adr.size()) begin
          check("cyc_adr", cyc_adr[idx], 32'(a));
          check("cyc_size", {30'd0, cyc_size[idx]}, 32'(r % 4));
          check("cyc_rw", {31'd0, cyc_rw[idx]}, {31'd0, rw});
        end
        a += nb; r -= nb; idx++;
      end
      check("cyc_count", 32'(cyc_adr.size()), 32'(idx));
    end
    $display("xfer rw=%0d addr=%08h size=%0d port=%0d cycles=%0d rdata=%08h err=%0d",
             rw, addr, sz, pc, cyc_adr.size(), rd, er);
  endtask

  logic [31:0] rd;
  logic        er;
  int          guard;
  int          pulses;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      slv_mem[i] = 8'($urandom());
      ref_mem[i] = slv_mem[i];
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", {28'd0, ASn, DSn, DBENn, RWn}, 32'hF);
    check("rst_adr", ADR_OUT, 32'h0);
    check("rst_data", DATA_OUT, 32'h0);
    check("rst_size", {30'd0, SIZE}, 32'h0);
    check("rst_ready_valid_err", {29'd0, req_ready, rsp_valid, rsp_err}, 32'h4);
    check("rst_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    RESETn = 1'b1;

    // Aligned long read, 32-bit port
    slv_mem[16] = 8'hDE; slv_mem[17] = 8'hAD; slv_mem[18] = 8'hBE; slv_mem[19] = 8'hEF;
    ref_mem[16] = 8'hDE; ref_mem[17] = 8'hAD; ref_mem[18] = 8'hBE; ref_mem[19] = 8'hEF;
    xfer(1'b1, 32'h10, 2'b00, 32'h0, 2'b00, rd, er);
    check("dir_long_read", rd, 32'hDEADBEEF);

    // Misaligned long write, 32-bit port
    xfer(1'b0, 32'h21, 2'b00, 32'h11223344, 2'b00, rd, er);
    check("dir_mis_data0", (cyc_data.size() > 0) ? cyc_data[0] : 32'hX, 32'h11112233);
    check("dir_mis_data1", (cyc_data.size() > 1) ? cyc_data[1] : 32'hX, 32'h44000000);
    check("dir_mis_mem", {slv_mem[33], slv_mem[34], slv_mem[35], slv_mem[36]}, 32'h11223344);

    // Long read from an 8-bit port
    xfer(1'b1, 32'h40, 2'b00, 32'h0, 2'b10, rd, er);
    check("dir_byte_port_read", rd, {slv_mem[64], slv_mem[65], slv_mem[66], slv_mem[67]});

    // Word write to a 16-bit port at an odd address
    xfer(1'b0, 32'h03, 2'b10, 32'h0000A5C3, 2'b01, rd, er);
    check("dir_word_data0", (cyc_data.size() > 0) ? cyc_data[0] : 32'hX, 32'hA5A5A5A5);
    check("dir_word_data1", (cyc_data.size() > 1) ? cyc_data[1] : 32'hX, 32'hC3000000);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      xfer(1'($urandom()), 32'($urandom_range(1, 1000)), 2'($urandom()), $urandom(),
           2'($urandom_range(0, 2)), rd, er);
    end

    // Silent slave: transfer aborts after 64 wait clocks
    no_resp   = 1'b1;
    wait_clks = 0;
    xfer(1'b1, 32'h80, 2'b00, 32'h0, 2'b00, rd, er);
    check("timeout_err", {31'd0, er}, 32'd1);
    check("timeout_wait_clks", 32'(wait_clks), 32'd64);
    @(negedge clk);
    check("timeout_ready", {28'd0, req_ready, ASn, DSn, DBENn}, 32'hF);

    // Reset during a wait state drops the transfer
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h100; req_size = 2'b00;
    @(posedge clk);
    #1 req_valid = 1'b0;
    guard = 0;
    while (DSn !== 1'b0 && guard < 20) begin @(negedge clk); guard++; end
    check("rst_test_in_wait", {31'd0, DSn}, 32'd0);
    repeat (3) @(negedge clk);
    RESETn = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_strobes", {28'd0, ASn, DSn, DBENn, RWn}, 32'hF);
    check("midrst_ready_valid", {30'd0, req_ready, rsp_valid}, 32'h2);
    check("midrst_adr_size", ADR_OUT | {30'd0, SIZE}, 32'h0);
    @(negedge clk);
    RESETn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("midrst_no_rsp", 32'(pulses), 32'd0);
    no_resp = 1'b0;
    xfer(1'b1, 32'h123, 2'b01, 32'h0, 2'b00, rd, er);
    check("post_rst_byte", rd, {24'd0, slv_mem[291]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m68030_bus_master.md
Name: m68030_bus_master

Overview:
- Bus initiator for the 68030-style asynchronous bus. It is the CPU-side counterpart of the block-RAM slave bridge.
- Takes single transfer requests (byte, word, 3-byte, long) from a simple valid/ready port and runs one or more bus cycles: ASn/DSn/DBENn strobes, SIZE, RWn.
- Performs dynamic bus sizing and misalignment splitting based on the DSACKn port-width response.
- Used as a stand-alone traffic generator to exercise memory slaves in simulation without the full CPU core.

Parameters:
- TIMEOUT, 64, clocks in S_WAIT without DSACKn before the transfer aborts with rsp_err.

Ports:
- clk  input  1  single system clock, all logic on rising edge
- RESETn  input  1  synchronous active-low reset
- req_valid  input  1  transfer request valid
- req_ready  output  1  high only in S_IDLE; request accepted when req_valid & req_ready
- req_rw  input  1  1=read, 0=write
- req_addr  input  32  byte address, any alignment
- req_size  input  2  68030 encoding: 00 long, 01 byte, 10 word, 11 three-byte
- req_wdata  input  32  write operand, right-justified (byte in [7:0], word in [15:0], 3-byte in [23:0])
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  32  read operand, right-justified, upper unused bytes zero; 0 on writes
- rsp_err  output  1  valid with rsp_valid; 1 = timeout abort
- ADR_OUT  output  32  current bus-cycle address
- DATA_OUT  output  32  write data lanes; lane0 = [31:24]
- DATA_IN  input  32  read data lanes
- SIZE  output  2  remaining-byte count of the current cycle, same encoding as req_size
- RWn  output  1  1 = read
- ASn  output  1  address strobe
- DSn  output  1  data strobe
- DBENn  output  1  data buffer enable; slaves respond while low
- DSACKn  input  2  {DSACKn[1],DSACKn[0]}: 00 = 32-bit port, 01 = 16-bit, 10 = 8-bit, 11 = wait

Behaviour:
- Reset (sync, RESETn low at an edge), takes effect at that edge even mid-transfer:
  - state S_IDLE; ASn=DSn=DBENn=1; RWn=1.
  - ADR_OUT=0, DATA_OUT=0, SIZE=00.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - The pending transfer is dropped with no response.
- Accept: latch addr into a (address register), remaining count r (long=4, byte=1, word=2, 3-byte=3), and operand bytes left-justified (r0 = most significant operand byte). Go to S_ADDR.
- S_ADDR (1 clk): drive ADR_OUT=a, SIZE=enc(r), RWn, DATA_OUT; ASn=0. Go to S_WAIT.
- S_WAIT: DSn=0, DBENn=0; timeout counter increments.
  - DSACKn==11: stay.
  - Counter reaches TIMEOUT: go to S_END with abort flag set.
  - Otherwise set port width P (4/2/1) and compute bytes moved n = min(r, P - (a mod P)).
    - Read: capture DATA_IN on this same edge. Port bytes come from lanes starting at a mod 4 (32-bit), a mod 2 (16-bit), or lane 0 (8-bit), n bytes. Append them to the read accumulator.
    - Then a += n, r -= n. Go to S_END.
- S_END: ASn=DSn=DBENn=1. Wait until DSACKn==11.
  - Then: r>0 and no abort → S_ADDR (next cycle); else → S_DONE.
- S_DONE (1 clk): rsp_valid=1, rsp_err=abort, rsp_rdata = accumulator right-justified (writes: 0). Then S_IDLE.
- Write lane rule: lanes L ≥ (a mod 4) carry r[L-(a mod 4)] while the index < r, else 00. Lanes L < (a mod 4):
  - lane0 = r0
  - lane1 = r1 if (a mod 4)=2, else r0
  - lane2 = r0
  - This gives correct bytes to 8-, 16- and 32-bit ports without knowing width in advance.
- SIZE=00 with r=4 only; r never exceeds 4. Address arithmetic wraps mod 2^32.
- DSACKn asserted in S_ADDR is ignored. DSACKn still asserted on entry to S_END holds the FSM there (no new cycle overlaps an old acknowledge).
- req_valid while busy is ignored. Inputs are not re-sampled until S_IDLE.

Test Plan:
- Aligned long read, 32-bit slave, mem[0x10..0x13]=DE AD BE EF, DSACKn=00 → one bus cycle (ADR_OUT=0x10, SIZE=00, RWn=1); rsp_rdata=0xDEADBEEF, rsp_err=0.
- Misaligned long write, addr 0x21, wdata 0x11223344, 32-bit slave → cycle 1: SIZE=00, DATA_OUT=0x11112233, writes 3 bytes; cycle 2: ADR_OUT=0x24, SIZE=01, lane0=0x44; memory 0x21..0x24 = 11 22 33 44.
- Long read from 8-bit slave (DSACKn=10), addr 0x40 → four cycles with ADR_OUT 0x40..0x43 and SIZE 00, 11, 10, 01; rsp_rdata assembled from lane0 in order.
- Word write to 16-bit slave (DSACKn=01), addr 0x03, wdata 0xA5C3 → two cycles: first at 0x03, SIZE=10, lane1=0xA5; second at 0x04, SIZE=01, lane0=0xC3.
- No-response slave (DSACKn held 11) → after TIMEOUT=64 S_WAIT clocks, strobes deassert; rsp_valid with rsp_err=1; req_ready returns.
- RESETn low for one edge while in S_WAIT → next state S_IDLE, all strobes 1, no rsp_valid; a fresh byte read then completes normally.
